// File: rtl/mfcc_frame_sequencer_if.sv
// Sample-in / RAM-write / read-request bus for the MFCC frame sequencer.
// Ports: in_sample/in_valid/in_ready (sample stream), buf_wr_* (sample RAM write port),
//        rd_valid/rd_ready/rd_addr/win_idx/rd_first/rd_last (windowing read requests).
interface mfcc_frame_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_sample;
  logic              in_valid;
  logic              in_ready;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [DATA_W-1:0] buf_wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        win_idx;
  logic              rd_first;
  logic              rd_last;

  // master: the sequencer itself; slave: sample source, RAM and windowing datapath.
  modport master (
    input  in_sample, in_valid, rd_ready,
    output in_ready, buf_wr_en, buf_wr_addr, buf_wr_data,
           rd_valid, rd_addr, win_idx, rd_first, rd_last
  );
  modport slave (
    output in_sample, in_valid, rd_ready,
    input  in_ready, buf_wr_en, buf_wr_addr, buf_wr_data,
           rd_valid, rd_addr, win_idx, rd_first, rd_last
  );
endinterface

// File: rtl/mfcc_frame_sequencer.sv
// Sequences MFCC framing: buffers samples in a circular RAM, issues per-frame read bursts, retires hop samples.
// Ports: clk, rst_n (async active-low), enable, cfg_frame_size/overlap, bus (mfcc_frame_sequencer_if.master),
//        frame_done, cfg_err; with FRAME_SEQ_STATS_EN defined also stat_frames and stat_stall.
module mfcc_frame_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  cfg_frame_size,
  input  logic [7:0]  cfg_frame_overlap,
  mfcc_frame_sequencer_if.master bus,
  output logic        frame_done,
  output logic        cfg_err
`ifdef FRAME_SEQ_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_stall
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, READ, RETIRE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        fs, ov, hop;
  logic [ADDR_W-1:0] wr_ptr, base, rd_addr_q;
  logic [ADDR_W:0]   occ;
  logic [7:0]        win_idx_q;
  logic              first_q, last_q;
  logic              cfg_ok, accept, rd_hs, last_hs;

  assign cfg_ok  = (cfg_frame_size >= 8'd2) && (cfg_frame_overlap < cfg_frame_size);
  assign hop     = fs - ov;
  // occ MSB set means all 2^ADDR_W entries hold unretired samples.
  assign bus.in_ready = (state != IDLE) && !occ[ADDR_W];
  assign accept  = bus.in_valid && bus.in_ready;
  assign rd_hs   = bus.rd_valid && bus.rd_ready;
  assign last_hs = rd_hs && (win_idx_q == fs - 8'd1);

  assign bus.buf_wr_en   = accept;
  assign bus.buf_wr_addr = wr_ptr;
  assign bus.buf_wr_data = accept ? bus.in_sample : '0;
  assign bus.rd_valid    = (state == READ);
  assign bus.rd_addr     = rd_addr_q;
  assign bus.win_idx     = win_idx_q;
  assign bus.rd_first    = first_q;
  assign bus.rd_last     = last_q;
  assign frame_done      = (state == RETIRE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && cfg_ok) state_nxt = WAIT;
      WAIT:    if (occ >= (ADDR_W+1)'(fs)) state_nxt = READ;
      READ:    if (last_hs) state_nxt = RETIRE;
      RETIRE:  state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fs        <= '0;
      ov        <= '0;
      cfg_err   <= 1'b0;
      wr_ptr    <= '0;
      base      <= '0;
      occ       <= '0;
      rd_addr_q <= '0;
      win_idx_q <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && enable) begin
        if (cfg_ok) begin
          fs      <= cfg_frame_size;
          ov      <= cfg_frame_overlap;
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end

      if (state_nxt == IDLE) begin
        // Abort path: everything restarts from an empty buffer.
        wr_ptr    <= '0;
        base      <= '0;
        occ       <= '0;
        rd_addr_q <= '0;
        win_idx_q <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        // Write and retire in the same cycle net in one update.
        occ <= occ + (ADDR_W+1)'(accept) - ((state == RETIRE) ? (ADDR_W+1)'(hop) : '0);
        if (state == RETIRE) base <= base + ADDR_W'(hop);
        if (state == WAIT) begin
          rd_addr_q <= base;
          win_idx_q <= '0;
        end else if (rd_hs) begin
          rd_addr_q <= rd_addr_q + 1'b1;
          win_idx_q <= win_idx_q + 8'd1;
        end
      end

      // first/last flags are registered alongside win_idx so they hold under backpressure.
      if (state_nxt == READ) begin
        if (state != READ) begin
          first_q <= 1'b1;
          last_q  <= 1'b0;
        end else if (rd_hs) begin
          first_q <= 1'b0;
          last_q  <= (win_idx_q == fs - 8'd2);
        end
      end else begin
        first_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

`ifdef FRAME_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_stall  <= '0;
    end else if (state == IDLE) begin
      stat_frames <= '0;
      stat_stall  <= '0;
    end else begin
      if (frame_done && stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
      if (bus.rd_valid && !bus.rd_ready && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Bench for mfcc_frame_sequencer: scoreboard of expected read requests, shadow sample RAM for data checks.
// Ports: none; drives the DUT through an mfcc_frame_sequencer_if instance plus plain control signals.
module tb_mfcc_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] cfg_fs = 8'd0;
  logic [7:0] cfg_ov = 8'd0;
  logic       frame_done, cfg_err;
`ifdef FRAME_SEQ_STATS_EN
  logic [15:0] stat_frames, stat_stall;
`endif

  mfcc_frame_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  mfcc_frame_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .cfg_frame_size    (cfg_fs),
    .cfg_frame_overlap (cfg_ov),
    .bus               (bus),
    .frame_done        (frame_done),
    .cfg_err           (cfg_err)
`ifdef FRAME_SEQ_STATS_EN
    ,
    .stat_frames       (stat_frames),
    .stat_stall        (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  idx;
    logic        first;
    logic        last;
    logic [15:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  rd_exp_t     e_mon;
  logic [15:0] mem [256];
  int          errors = 0, checks = 0;
  int          to_send = 0, next_sample = 0, accepted = 0;
  int          hs_cnt = 0, fd_cnt = 0, stall_cnt = 0, rr_mode = 0;
  logic [7:0]  wr_exp = 8'd0;
  logic        tog = 1'b0;
  logic        prev_stall = 1'b0, prev_last_hs = 1'b0;
  logic [7:0]  prev_addr = 8'd0, prev_idx = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Driver: inputs change 1 time unit after the active edge.
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.rd_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.in_valid  = (to_send > 0);
      bus.in_sample = next_sample[15:0];
      tog           = ~tog;
      bus.rd_ready  = (sb.size() > 0) && (rr_mode == 0 || (rr_mode == 1 && tog));
    end
  end

  // Monitor: samples on the falling edge, half a cycle from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", bus.rd_valid, 1);
        check("hold_addr", bus.rd_addr, prev_addr);
        check("hold_idx", bus.win_idx, prev_idx);
      end
      check("wr_en", bus.buf_wr_en, bus.in_valid && bus.in_ready);
      if (bus.in_valid && bus.in_ready) begin
        check("wr_addr", bus.buf_wr_addr, wr_exp);
        check("wr_data", bus.buf_wr_data, next_sample[15:0]);
        mem[bus.buf_wr_addr] = bus.buf_wr_data;
        wr_exp++;
        to_send--;
        next_sample++;
        accepted++;
      end
      if (frame_done) begin
        fd_cnt++;
        check("fd_after_last", prev_last_hs, 1);
      end
      prev_last_hs = 1'b0;
      if (bus.rd_valid && bus.rd_ready) begin
        hs_cnt++;
        check("rd_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e_mon = sb.pop_front();
          check("rd_addr", bus.rd_addr, e_mon.addr);
          check("win_idx", bus.win_idx, e_mon.idx);
          check("rd_first", bus.rd_first, e_mon.first);
          check("rd_last", bus.rd_last, e_mon.last);
          check("rd_data", mem[bus.rd_addr], e_mon.data);
          prev_last_hs = e_mon.last;
        end
      end
      if (bus.rd_valid && !bus.rd_ready) stall_cnt++;
      prev_stall = bus.rd_valid && !bus.rd_ready && enable;
      prev_addr  = bus.rd_addr;
      prev_idx   = bus.win_idx;
    end
  end

  task automatic check_all_zero(input string p);
    check({p, "_in_ready"}, bus.in_ready, 0);
    check({p, "_wr_en"}, bus.buf_wr_en, 0);
    check({p, "_wr_addr"}, bus.buf_wr_addr, 0);
    check({p, "_wr_data"}, bus.buf_wr_data, 0);
    check({p, "_rd_valid"}, bus.rd_valid, 0);
    check({p, "_rd_addr"}, bus.rd_addr, 0);
    check({p, "_win_idx"}, bus.win_idx, 0);
    check({p, "_rd_first"}, bus.rd_first, 0);
    check({p, "_rd_last"}, bus.rd_last, 0);
    check({p, "_frame_done"}, frame_done, 0);
    check({p, "_cfg_err"}, cfg_err, 0);
  endtask

  // Expected requests: frame k, index i reads absolute sample k*hop+i.
  task automatic push_frames(input int fs, input int hop, input int n);
    rd_exp_t e;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < fs; i++) begin
        e.addr  = 8'((k * hop + i) % 256);
        e.idx   = 8'(i);
        e.first = (i == 0);
        e.last  = (i == fs - 1);
        e.data  = 16'(k * hop + i);
        sb.push_back(e);
      end
    end
  endtask

  task automatic start_test(input int fs, input int ov, input int nframes, input int nsamples, input int mode);
    to_send = 0;
    sb.delete();
    enable = 1'b0;
    tick();
    tick();
    next_sample = 0;
    wr_exp      = 8'd0;
    accepted    = 0;
    hs_cnt      = 0;
    fd_cnt      = 0;
    stall_cnt   = 0;
    rr_mode     = mode;
    cfg_fs      = 8'(fs);
    cfg_ov      = 8'(ov);
    push_frames(fs, fs - ov, nframes);
    to_send     = nsamples;
    enable      = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("sb_drain", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Overlapping frames: fs=8, ov=4, 16 samples.
    start_test(8, 4, 2, 16, 0);
    wait_drain(300);
    repeat (4) tick();
    check("a_frames", fd_cnt, 2);
    check("a_accepted", accepted, 16);
    check("a_third_vld", bus.rd_valid, 1);
    check("a_third_addr", bus.rd_addr, 8);
    check("a_third_idx", bus.win_idx, 0);
    check("a_third_first", bus.rd_first, 1);

    // Rejected config, then a valid non-overlapping one under toggled rd_ready.
    to_send = 0;
    sb.delete();
    enable = 1'b0;
    tick();
    tick();
    cfg_fs = 8'd4;
    cfg_ov = 8'd4;
    enable = 1'b1;
    tick();
    tick();
    check("b_cfg_err", cfg_err, 1);
    check("b_idle_in_ready", bus.in_ready, 0);
    check("b_idle_rd_valid", bus.rd_valid, 0);
    start_test(4, 0, 3, 12, 1);
    tick();
    check("b_cfg_err_clr", cfg_err, 0);
    wait_drain(300);
    repeat (4) tick();
    check("b_frames", fd_cnt, 3);
    check("b_accepted", accepted, 12);
    check("b_no_more", bus.rd_valid, 0);
    check("b_in_ready", bus.in_ready, 1);
`ifdef FRAME_SEQ_STATS_EN
    check("b_stat_frames", stat_frames, 3);
    check("b_stat_stall", stat_stall, stall_cnt);
    enable = 1'b0;
    tick();
    tick();
    check("b_stat_frames_clr", stat_frames, 0);
    check("b_stat_stall_clr", stat_stall, 0);
`endif

    // Backpressure: one fs=8 frame with alternating rd_ready.
    start_test(8, 0, 1, 8, 1);
    wait_drain(300);
    repeat (3) tick();
    check("c_handshakes", hs_cnt, 8);
    check("c_frames", fd_cnt, 1);
    check("c_stalled", stall_cnt != 0, 1);

    // Full buffer and wrap: fs=200, ov=100, reads held off until the RAM is full.
    start_test(200, 100, 3, 400, 2);
    n = 0;
    while (accepted < 256 && n < 1000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("d_full_accepted", accepted, 256);
    check("d_full_in_ready", bus.in_ready, 0);
    check("d_full_rd_valid", bus.rd_valid, 1);
    check("d_full_rd_addr", bus.rd_addr, 0);
    check("d_full_hs", hs_cnt, 0);
    rr_mode = 0;
    wait_drain(3000);
    repeat (4) tick();
    check("d_frames", fd_cnt, 3);
    check("d_accepted", accepted, 400);

    // Reset asserted mid-READ at win_idx=5.
    start_test(8, 4, 1, 16, 0);
    n = 0;
    while (!(bus.rd_valid && bus.win_idx == 8'd5) && n < 300) begin
      tick();
      n++;
    end
    check("e_reached_idx5", bus.win_idx, 5);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    to_send = 0;
    sb.delete();
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("e_post_in_ready", bus.in_ready, 0);
    check("e_post_rd_valid", bus.rd_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
